out_img_streamer: RTL and testbench



---
 rtl/out_img_streamer.sv | 177 +++++++++++++++++
 tb/tb_out_img_streamer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_img_streamer.sv
// Output image streamer: reads a frame linearly from the output image memory and emits it as an
// 8-bit valid/ready stream with end-of-line/end-of-frame tags. OUT_STREAM_CKSUM_EN adds a 16-bit checksum.
module out_img_streamer #(
    parameter int unsigned AW     = 12,
    parameter int unsigned FIFO_D = 2
) (
    input  logic          clk_50,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   i_out_w,
    input  logic [15:0]   i_out_h,
    output logic [AW-1:0] mem_raddr,
    input  logic [7:0]    mem_rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [7:0]    m_data,
    output logic          m_eol,
    output logic          m_last,
    output logic          busy,
    output logic          done,
    output logic          o_err_size,
    output logic [15:0]   o_checksum
);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned OW  = $clog2(FIFO_D + 1);
    localparam int unsigned OW1 = OW + 1;
    localparam logic [32:0] CAP = 33'(1) << AW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ERR} state_t;
    state_t state_q, state_d;

    logic [15:0]   w_q, h_q, x_q, y_q;
    logic [CW-1:0] n_q, rd_cnt_q, acc_cnt_q;
    logic          rd_pending_q;
    logic [7:0]    fifo_q [FIFO_D];
    logic [7:0]    fifo_d [FIFO_D];
    logic [OW-1:0] occ_q, occ_d, occ_pop_c;

    logic [31:0] n_c;
    logic        size_bad_c, accept_c, issue_c, hs_c, final_hs_c, room_ok_c;
    logic        x_end_c, eol_nx_c, last_nx_c;
    logic [15:0] x_nx_c, y_nx_c;

    assign n_c        = 32'(i_out_w) * 32'(i_out_h);
    assign size_bad_c = (i_out_w == 16'd0) || (i_out_h == 16'd0) || (33'(n_c) > CAP);
    assign hs_c       = m_valid && m_ready;
    assign final_hs_c = hs_c && (acc_cnt_q == n_q - CW'(1));
    // A pop in this cycle frees a slot, which keeps one beat per cycle with two entries.
    assign room_ok_c  = (OW1'(occ_q) + OW1'(rd_pending_q) - OW1'(hs_c)) < OW1'(FIFO_D);
    assign m_data     = fifo_q[0];

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        issue_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (size_bad_c) begin
                        state_d = S_ERR;
                    end else begin
                        state_d  = S_RUN;
                        accept_c = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (room_ok_c) begin
                    issue_c = 1'b1;
                    if (rd_cnt_q == n_q - CW'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (final_hs_c) state_d = S_IDLE;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Line/frame position of the beat following the current head.
    always_comb begin
        x_end_c   = (x_q == w_q - 16'd1);
        x_nx_c    = x_end_c ? 16'd0 : x_q + 16'd1;
        y_nx_c    = x_end_c ? y_q + 16'd1 : y_q;
        eol_nx_c  = (x_nx_c == w_q - 16'd1);
        last_nx_c = eol_nx_c && (y_nx_c == h_q - 16'd1);
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            w_q          <= '0;
            h_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            n_q          <= '0;
            rd_cnt_q     <= '0;
            acc_cnt_q    <= '0;
            rd_pending_q <= 1'b0;
            mem_raddr    <= '0;
            m_eol        <= 1'b0;
            m_last       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            o_err_size   <= 1'b0;
        end else begin
            busy         <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done         <= (state_q == S_ERR) || ((state_q == S_DRAIN) && final_hs_c);
            rd_pending_q <= issue_c;
            if (state_q == S_ERR) o_err_size <= 1'b1;
            if (accept_c) begin
                w_q        <= i_out_w;
                h_q        <= i_out_h;
                n_q        <= CW'(n_c);
                rd_cnt_q   <= '0;
                acc_cnt_q  <= '0;
                x_q        <= '0;
                y_q        <= '0;
                o_err_size <= 1'b0;
                m_eol      <= (i_out_w == 16'd1);
                m_last     <= (i_out_w == 16'd1) && (i_out_h == 16'd1);
            end
            if (issue_c) begin
                mem_raddr <= rd_cnt_q[AW-1:0];
                rd_cnt_q  <= rd_cnt_q + CW'(1);
            end
            if (hs_c) begin
                acc_cnt_q <= acc_cnt_q + CW'(1);
                x_q       <= x_nx_c;
                y_q       <= y_nx_c;
                m_eol     <= eol_nx_c;
                m_last    <= last_nx_c;
            end
        end
    end

    // Shift-register FIFO: entry 0 is always the head, so m_data comes straight from a flop.
    always_comb begin
        occ_pop_c = occ_q - OW'(hs_c);
        fifo_d    = fifo_q;
        if (hs_c) begin
            for (int i = 0; i < int'(FIFO_D) - 1; i++) fifo_d[i] = fifo_q[i+1];
        end
        for (int i = 0; i < int'(FIFO_D); i++) begin
            if (rd_pending_q && (occ_pop_c == OW'(i))) fifo_d[i] = mem_rdata;
        end
        occ_d = occ_pop_c + OW'(rd_pending_q);
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_D); i++) fifo_q[i] <= '0;
            occ_q   <= '0;
            m_valid <= 1'b0;
        end else begin
            fifo_q  <= fifo_d;
            occ_q   <= occ_d;
            m_valid <= (occ_d != '0);
        end
    end

`ifdef OUT_STREAM_CKSUM_EN
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n)        o_checksum <= '0;
        else if (accept_c) o_checksum <= '0;
        else if (hs_c)     o_checksum <= o_checksum + 16'(m_data);
    end
`else
    assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_out_img_streamer.sv
// Self-checking bench for out_img_streamer: randomized frames and ready patterns against a beat-list model.
module tb_out_img_streamer;
    localparam int unsigned AW     = 12;
    localparam int unsigned FIFO_D = 2;
`ifdef OUT_STREAM_CKSUM_EN
    localparam bit CK_ON = 1'b1;
`else
    localparam bit CK_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       eol;
        logic       last;
    } beat_t;

    logic          clk_50, rst_n, start, m_valid, m_ready, m_eol, m_last, busy, done, o_err_size;
    logic [15:0]   i_out_w, i_out_h, o_checksum;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata, m_data;
    logic [7:0]    mem [4096];

    beat_t exp_q[$];
    beat_t prev_b;
    bit    stall_prev;
    int    n_checks, n_err, cyc, done_cnt, done_cyc, last_hs_cyc, rdy_mode;
    logic [7:0] eol_hist, last_hist;

    out_img_streamer #(.AW(AW), .FIFO_D(FIFO_D)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .start(start), .i_out_w(i_out_w), .i_out_h(i_out_h),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_eol(m_eol), .m_last(m_last), .busy(busy), .done(done),
        .o_err_size(o_err_size), .o_checksum(o_checksum)
    );

    assign mem_rdata = mem[mem_raddr];

    initial begin
        clk_50 = 1'b0;
        forever #10 clk_50 = ~clk_50;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    // Consumer ready pattern: 0 always, 1 toggling, 2 random, 3 held low.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk_50);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Compare process: every accepted beat must be the next beat of the model list.
    always @(negedge clk_50) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            cyc++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stall_prev) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(prev_b.d));
                chk("stall_eol", 32'(m_eol), 32'(prev_b.eol));
                chk("stall_last", 32'(m_last), 32'(prev_b.last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL extra_beat: got data %0d, expected no beat (t=%0t)", m_data, $time);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(m_data), 32'(e.d));
                    chk("beat_eol", 32'(m_eol), 32'(e.eol));
                    chk("beat_last", 32'(m_last), 32'(e.last));
                    eol_hist  = {eol_hist[6:0], m_eol};
                    last_hist = {last_hist[6:0], m_last};
                    if (e.last) last_hs_cyc = cyc;
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_b     = '{d: m_data, eol: m_eol, last: m_last};
        end
    end

    // fill: 0 -> mem[k] = k mod 256, 1 -> random bytes.
    task automatic run_frame(input int w, input int h, input int fill, input int mode,
                             input bit stall20, input bit restart);
        int n, exp_sum, d0, budget;
        n       = w * h;
        exp_sum = 0;
        for (int k = 0; k < n; k++) begin
            mem[k] = (fill == 0) ? 8'(k) : 8'($urandom);
            exp_q.push_back('{d: mem[k], eol: ((k % w) == w - 1), last: (k == n - 1)});
            exp_sum += int'(mem[k]);
        end
        d0       = done_cnt;
        eol_hist = '0;
        last_hist = '0;
        rdy_mode = stall20 ? 3 : mode;
        tick();
        start   = 1'b1;
        i_out_w = 16'(w);
        i_out_h = 16'(h);
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        tick();
        chk("valid_latency_early", 32'(m_valid), 32'd0);
        tick();
        chk("valid_latency", 32'(m_valid), 32'd1);
        if (stall20) begin
            repeat (17) tick();
            chk("outstanding_reads", 32'(mem_raddr <= AW'(FIFO_D - 1)), 32'd1);
            chk("stalled_head", 32'(m_data), 32'(mem[0]));
            chk("stalled_queue", 32'(exp_q.size()), 32'(n));
            rdy_mode = 0;
        end
        if (restart) begin
            budget = 1000;
            while (exp_q.size() > n - 5 && budget > 0) begin
                tick();
                budget--;
            end
            start   = 1'b1;
            i_out_w = 16'd3;
            i_out_h = 16'd3;
            tick();
            start = 1'b0;
        end
        budget = 4 * n + 200;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        chk("frame_complete_remaining", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
        chk("done_count", 32'(done_cnt - d0), 32'd1);
        chk("done_timing", 32'(done_cyc), 32'(last_hs_cyc + 1));
        chk("busy_end", 32'(busy), 32'd0);
        chk("valid_end", 32'(m_valid), 32'd0);
        chk("err_clear", 32'(o_err_size), 32'd0);
        chk("checksum", 32'(o_checksum), CK_ON ? 32'(exp_sum % 65536) : 32'd0);
    endtask

    task automatic run_err(input int w, input int h);
        int d0;
        exp_q.delete();
        rdy_mode = 0;
        d0 = done_cnt;
        tick();
        start   = 1'b1;
        i_out_w = 16'(w);
        i_out_h = 16'(h);
        tick();
        start = 1'b0;
        chk("err_done_early", 32'(done), 32'd0);
        chk("err_valid0", 32'(m_valid), 32'd0);
        tick();
        chk("err_done", 32'(done), 32'd1);
        chk("err_flag", 32'(o_err_size), 32'd1);
        chk("err_valid1", 32'(m_valid), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
        tick();
        chk("err_done_single", 32'(done), 32'd0);
        chk("err_flag_sticky", 32'(o_err_size), 32'd1);
        chk("err_valid2", 32'(m_valid), 32'd0);
        chk("err_done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_data"}, 32'(m_data), 32'd0);
        chk({tag, "_eol"}, 32'(m_eol), 32'd0);
        chk({tag, "_last"}, 32'(m_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(o_err_size), 32'd0);
        chk({tag, "_cksum"}, 32'(o_checksum), 32'd0);
        chk({tag, "_raddr"}, 32'(mem_raddr), 32'd0);
    endtask

    initial begin
        int d0, budget, n;
        n_checks = 0; n_err = 0; cyc = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
        rdy_mode = 0; stall_prev = 1'b0; eol_hist = '0; last_hist = '0;
        rst_n = 1'b0; start = 1'b0; i_out_w = '0; i_out_h = '0;
        for (int k = 0; k < 4096; k++) mem[k] = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        run_frame(4, 2, 0, 0, 1'b0, 1'b0);
        chk("lit_eol_pattern", 32'(eol_hist), 32'h11);
        chk("lit_last_pattern", 32'(last_hist), 32'h01);
        chk("lit_cksum_28", 32'(o_checksum), CK_ON ? 32'd28 : 32'd0);

        run_frame(4, 2, 0, 1, 1'b0, 1'b0);
        chk("lit_toggle_eol", 32'(eol_hist), 32'h11);
        chk("lit_toggle_cksum", 32'(o_checksum), CK_ON ? 32'd28 : 32'd0);

        run_frame(64, 64, 0, 0, 1'b0, 1'b0);
        chk("lit_cksum_63488", 32'(o_checksum), CK_ON ? 32'd63488 : 32'd0);

        run_err(0, 5);
        run_err(64, 65);
        run_err(4097, 1);
        run_frame(1, 1, 1, 2, 1'b0, 1'b0);
        run_frame(4096, 1, 1, 0, 1'b0, 1'b0);
        run_frame(16, 4, 1, 0, 1'b0, 1'b1);

        // Reset after ten accepted beats aborts the frame without a done pulse.
        n = 32;
        for (int k = 0; k < n; k++) begin
            mem[k] = 8'($urandom);
            exp_q.push_back('{d: mem[k], eol: ((k % 8) == 7), last: (k == n - 1)});
        end
        rdy_mode = 0;
        tick();
        start = 1'b1; i_out_w = 16'd8; i_out_h = 16'd4;
        tick();
        start = 1'b0;
        budget = 200;
        while (exp_q.size() > n - 10 && budget > 0) begin
            tick();
            budget--;
        end
        chk("reset_point_beats", 32'(n - exp_q.size()), 32'd10);
        rst_n = 1'b0;
        d0 = done_cnt;
        tick();
        chk_all_zero("midreset");
        exp_q.delete();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("midreset_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midreset_idle_valid", 32'(m_valid), 32'd0);
        run_frame(5, 3, 1, 2, 1'b0, 1'b0);

        run_frame(4, 2, 0, 0, 1'b1, 1'b0);
        chk("lit_stall_cksum", 32'(o_checksum), CK_ON ? 32'd28 : 32'd0);

        for (int r = 0; r < 8; r++) begin
            run_frame(int'($urandom_range(1, 20)), int'($urandom_range(1, 10)), 1,
                      int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
